// File: rtl/digit_serializer_if.sv
// Handshake bundle for digit_serializer: value input channel and digit output channel.
// The block is the slave; the producer/consumer side is the master.
interface digit_serializer_if #(
  parameter int unsigned DW = 4
);
  localparam int unsigned N = 2 ** DW;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [DW-1:0] in_shift;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_digit;
  logic          out_last;
  logic [DW:0]   out_index;

  modport master (
    output in_valid, in_data, in_shift, out_ready,
    input  in_ready, out_valid, out_digit, out_last, out_index
  );

  modport slave (
    input  in_valid, in_data, in_shift, out_ready,
    output in_ready, out_valid, out_digit, out_last, out_index
  );
endinterface

// File: rtl/digit_serializer.sv
// Splits an unsigned 2**DW-bit value into radix-2^S digits, LSB digit first, one per cycle.
// Define DIGIT_SERIALIZER_LEADZERO_EN to always emit ceil(2**DW / S) digits, leading zeros included.
module digit_serializer #(
  parameter int unsigned DW = 4
) (
  input logic               clk,
  input logic               rst,
  digit_serializer_if.slave bus
);
  localparam int unsigned N  = 2 ** DW;
  localparam int unsigned CW = DW + 1;
  localparam logic [DW:0] IdxOne = (DW + 1)'(1);

  typedef enum logic {StIdle, StEmit} state_e;

  state_e          r_state;
  logic [N-1:0]    r_work;
  logic [DW-1:0]   r_shift;
  logic [CW-1:0]   r_cons;
  logic [DW:0]     r_index;

  state_e          w_state_d;
  logic [N-1:0]    w_work_d;
  logic [DW-1:0]   w_shift_d;
  logic [CW-1:0]   w_cons_d;
  logic [DW:0]     w_index_d;

  logic [N-1:0]    w_rem;
  logic [N-1:0]    w_mask;
  logic [DW-1:0]   w_shift_in;
  logic            w_done;
  logic            w_last;
  logic            w_emit;

  assign w_emit     = (r_state == StEmit);
  assign w_rem      = r_work >> r_shift;
  assign w_mask     = ~({N{1'b1}} << r_shift);
  assign w_done     = (r_cons >= CW'(N));
  // A zero digit width would never make progress, so it is treated as 1.
  assign w_shift_in = (bus.in_shift == '0) ? DW'(1) : bus.in_shift;

`ifdef DIGIT_SERIALIZER_LEADZERO_EN
  assign w_last = w_done;
`else
  assign w_last = (w_rem == '0) || w_done;
`endif

  always_comb begin
    bus.in_ready  = ~w_emit;
    bus.out_valid = w_emit;
    bus.out_digit = w_emit ? (r_work & w_mask) : '0;
    bus.out_last  = w_emit & w_last;
    bus.out_index = w_emit ? r_index : '0;
  end

  always_comb begin
    w_state_d = r_state;
    w_work_d  = r_work;
    w_shift_d = r_shift;
    w_cons_d  = r_cons;
    w_index_d = r_index;
    unique case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_work_d  = bus.in_data;
          w_shift_d = w_shift_in;
          w_cons_d  = CW'(w_shift_in);
          w_index_d = '0;
          w_state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (w_last) begin
            w_state_d = StIdle;
          end else begin
            w_work_d  = w_rem;
            w_cons_d  = r_cons + CW'(r_shift);
            w_index_d = r_index + IdxOne;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_work  <= '0;
      r_shift <= '0;
      r_cons  <= '0;
      r_index <= '0;
    end else begin
      r_state <= w_state_d;
      r_work  <= w_work_d;
      r_shift <= w_shift_d;
      r_cons  <= w_cons_d;
      r_index <= w_index_d;
    end
  end
endmodule

// File: tb/tb_digit_serializer.sv
// Directed, table-driven bench for digit_serializer (DW=4), plus backpressure and reset sequences.
module tb_digit_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  digit_serializer_if #(.DW(4)) bus ();

  digit_serializer #(.DW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      data;
    logic [3:0]       shift;
    int               n;
    logic [5:0][15:0] d;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [15:0] data, input logic [3:0] shift, input int n,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3,
                              input logic [15:0] d4, input logic [15:0] d5);
    vec_t v;
    v.data  = data;
    v.shift = shift;
    v.n     = n;
    v.d     = {d5, d4, d3, d2, d1, d0};
    vecs.push_back(v);
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 32'(bus.in_ready), 32'd1);
  endtask

  // Offer a value; returns at the negedge where digit 0 is presented.
  task automatic offer(input logic [15:0] data, input logic [3:0] shift);
    wait_idle();
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_shift = shift;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hDEAD;
    bus.in_shift = 4'd7;
  endtask

  task automatic chk_digit(input string tag, input int k, input logic [15:0] d, input bit last);
    chk($sformatf("%s[%0d].valid", tag, k), 32'(bus.out_valid), 32'd1);
    chk($sformatf("%s[%0d].in_ready", tag, k), 32'(bus.in_ready), 32'd0);
    chk($sformatf("%s[%0d].digit", tag, k), 32'(bus.out_digit), 32'(d));
    chk($sformatf("%s[%0d].index", tag, k), 32'(bus.out_index), 32'(k));
    chk($sformatf("%s[%0d].last", tag, k), 32'(bus.out_last), 32'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".out_digit"}, 32'(bus.out_digit), 32'd0);
    chk({tag, ".out_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, ".out_index"}, 32'(bus.out_index), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    bus.in_shift  = 4'd4;
    bus.out_ready = 1'b1;

    // Reset with in_valid asserted: nothing may be accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset_hold");
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");

    add(16'h1234, 4'd4, 4, 16'h4, 16'h3, 16'h2, 16'h1, 16'h0, 16'h0);
`ifdef DIGIT_SERIALIZER_LEADZERO_EN
    add(16'h0000, 4'd4, 4, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    add(16'h00AB, 4'd4, 4, 16'hB, 16'hA, 16'h0, 16'h0, 16'h0, 16'h0);
`else
    add(16'h0000, 4'd4, 1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    add(16'h00AB, 4'd4, 2, 16'hB, 16'hA, 16'h0, 16'h0, 16'h0, 16'h0);
    add(16'h0005, 4'd0, 3, 16'h1, 16'h0, 16'h1, 16'h0, 16'h0, 16'h0);
`endif
    add(16'hFFFF, 4'd3, 6, 16'h7, 16'h7, 16'h7, 16'h7, 16'h7, 16'h1);
    add(16'h8001, 4'd5, 4, 16'h1, 16'h0, 16'h0, 16'h1, 16'h0, 16'h0);
    add(16'hFFFF, 4'd15, 2, 16'h7FFF, 16'h1, 16'h0, 16'h0, 16'h0, 16'h0);

    foreach (vecs[i]) begin
      offer(vecs[i].data, vecs[i].shift);
      for (int k = 0; k < vecs[i].n; k++) begin
        chk_digit($sformatf("vec%0d", i), k, vecs[i].d[k], k == vecs[i].n - 1);
        @(negedge clk);
      end
      chk_idle($sformatf("vec%0d.end", i));
    end

    // Backpressure on index 1 of 0x1234; in_data changes must be ignored meanwhile.
    offer(16'h1234, 4'd4);
    chk_digit("bp", 0, 16'h4, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk_digit("bp_hold", 1, 16'h3, 1'b0);
      @(negedge clk);
    end
    chk_digit("bp_hold", 1, 16'h3, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_digit("bp", 2, 16'h2, 1'b0);
    @(negedge clk);
    chk_digit("bp", 3, 16'h1, 1'b1);
    // in_valid held high over the last digit: must not be taken until IDLE.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0021;
    bus.in_shift = 4'd4;
    @(negedge clk);
    chk("gap.in_ready", 32'(bus.in_ready), 32'd1);
    chk("gap.out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_digit("gap", 0, 16'h1, 1'b0);
    @(negedge clk);
    chk_digit("gap", 1, 16'h2, 1'b1);
    @(negedge clk);

    // Reset mid-emission at index 2, then a fresh value.
    offer(16'h1234, 4'd4);
    @(negedge clk);
    @(negedge clk);
    chk_digit("rst_mid", 2, 16'h2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst_mid.after");
    offer(16'h0021, 4'd4);
    chk_digit("post_rst", 0, 16'h1, 1'b0);
    @(negedge clk);
    chk_digit("post_rst", 1, 16'h2, 1'b1);
    @(negedge clk);
    chk_idle("post_rst.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/digit_serializer.md
DIGIT_SERIALIZER -- requirements
Module: digit_serializer

Interface
REQ-001 The block SHALL have parameter DW, default 4; data width is 2**DW bits (16 at default).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a value is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a value this cycle.
REQ-006 The block SHALL have port in_data, input, 2**DW bits: the unsigned value to split into digits.
REQ-007 The block SHALL have port in_shift, input, DW bits: the digit width S; the radix is 2^S.
REQ-008 The block SHALL have port out_valid, output, 1 bit: a digit is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the digit.
REQ-010 The block SHALL have port out_digit, output, 2**DW bits: the current digit, equal to the remainder modulo 2^S and zero-extended.
REQ-011 The block SHALL have port out_last, output, 1 bit: the current digit is the final digit of the value.
REQ-012 The block SHALL have port out_index, output, DW+1 bits: the digit position, with 0 as the least-significant digit.

Function
REQ-013 The block SHALL be a two-state FSM with states IDLE and EMIT.
REQ-014 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in EMIT, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-015 On the IDLE cycle with in_valid=1, the block SHALL latch in_data into work register W and latch S (an in_shift value of 0 is coerced to 1), set out_index=0, and go to EMIT. Latency is 1 cycle to the first digit.
REQ-016 In EMIT, the outputs SHALL be combinational from registers: out_digit = W & ~(all-ones << S), and out_last per REQ-020/021.
REQ-017 While out_ready=0 in EMIT, out_digit, out_last, out_index and W SHALL hold stable.
REQ-018 On an EMIT cycle with out_ready=1 and out_last=0, the block SHALL update W <= W >> S and out_index <= out_index+1, and stay in EMIT. The result is one digit per cycle under continuous ready.
REQ-019 On an EMIT cycle with out_ready=1 and out_last=1, the block SHALL return to IDLE. A new value SHALL NOT be accepted in the same cycle; the earliest acceptance is the following cycle, so the inter-value gap is 1 cycle minimum.
REQ-020 The block SHALL track consumed bits C = (out_index+1)*S in a register. With no compile-time option, out_last SHALL be 1 when (W >> S) == 0 or C >= 2**DW. This emits at least one digit and suppresses leading zeros.
REQ-021 The final digit SHALL contain only the remaining bits when 2**DW is not a multiple of S; zero-fill SHALL come from the shift.
REQ-022 in_data and in_shift SHALL be ignored outside the IDLE acceptance cycle.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL enter IDLE and clear W, S, C and out_index to 0, regardless of state. Any digit in progress is discarded with no out_last.
REQ-024 During and after reset, the outputs SHALL be in_ready=1, out_valid=0, out_digit=0, out_last=0 and out_index=0.
REQ-025 When rst and in_valid are both 1, reset SHALL take priority and the value SHALL NOT be accepted.

Configuration
REQ-026 The block SHALL support the macro DIGIT_SERIALIZER_LEADZERO_EN.
REQ-027 When DIGIT_SERIALIZER_LEADZERO_EN is defined, out_last SHALL be 1 only when C >= 2**DW. This always emits exactly ceil(2**DW / S) digits, including leading zeros.
REQ-028 When DIGIT_SERIALIZER_LEADZERO_EN is undefined, the block SHALL behave per REQ-020.

Verification
REQ-029 in_data=0x1234, S=4, out_ready=1 -> digits 4,3,2,1 on 4 consecutive cycles with out_index 0..3 and out_last on 1.
REQ-030 in_data=0x0000, S=4 -> undefined macro: one digit 0 with out_last=1; macro defined: digits 0,0,0,0 with out_last on the 4th.
REQ-031 in_data=0x00AB, S=4, macro defined -> digits B,A,0,0; macro undefined -> B,A only.
REQ-032 in_data=0xFFFF, S=3 -> digits 7,7,7,7,7,1 with out_last on the 6th; in_shift=0 with in_data=0x0005 -> digits 1,0,1.
REQ-033 Backpressure: out_ready held low for 3 cycles on digit index 1 of 0x1234 -> out_digit=3 is held stable, then the sequence resumes unchanged; in_ready=0 throughout.
REQ-034 rst pulsed 1 cycle while emitting index 2 of 0x1234 -> next cycle shows IDLE with in_ready=1, out_valid=0 and all outputs 0; a new value 0x0021, S=4 then yields 1,2.
